// File: rtl/order_pkg.sv
// order_pkg
// Shared definitions for the ordering-chain controller.
//   state_e         : controller states IDLE, FOOD, DRINK, PAY, CONFIRM, DONE
//   FOOD_W/DRINK_W/PAY_W : widths of the menu option codes
//   STAGE_*         : one-hot stage_en encodings (bit0 food, bit1 drink, bit2 pay)
//   stage_of()      : maps a state to its stage_en value
package order_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FOOD,
        DRINK,
        PAY,
        CONFIRM,
        DONE
    } state_e;

    localparam int FOOD_W  = 2;
    localparam int DRINK_W = 2;
    localparam int PAY_W   = 1;

    localparam logic [2:0] STAGE_NONE  = 3'b000;
    localparam logic [2:0] STAGE_FOOD  = 3'b001;
    localparam logic [2:0] STAGE_DRINK = 3'b010;
    localparam logic [2:0] STAGE_PAY   = 3'b100;

    // Only the three menu stages own a menu; CONFIRM/DONE/IDLE enable none.
    function automatic logic [2:0] stage_of(input state_e s);
        case (s)
            FOOD:    stage_of = STAGE_FOOD;
            DRINK:   stage_of = STAGE_DRINK;
            PAY:     stage_of = STAGE_PAY;
            default: stage_of = STAGE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Synchronises one raw panel button, debounces it and emits a one-cycle
// event on each accepted press (rising edge of the accepted level).
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   btn_i   : raw button, active-high, asynchronous to clk
//   event_o : one-cycle pulse, 2 + DEB_CYCLES + 1 clk after a clean press
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic event_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic          event_q;

    // The counter tracks how many consecutive synchronised samples disagree
    // with the accepted level; any agreeing sample restarts the count, so
    // bounce shorter than DEB_CYCLES never reaches the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            event_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            // Release (falling accepted level) deliberately produces nothing.
            event_q      <= level_q & ~level_prev_q;
        end
    end

    assign event_o = event_q;

endmodule

// File: rtl/order_sequencer.sv
// order_sequencer
// Central controller for the food -> drink -> payment -> confirm ordering
// chain. Debounces the four panel buttons, arbitrates their events, routes
// navigation to the active menu, latches each stage's choice and reports the
// finished order.
//   clk, reset          : system clock, asynchronous active-low reset
//   btn_next/back/sel/cancel : raw active-high panel buttons
//   food_code/drink_code/pay_code : currently highlighted menu options
//   stage_en            : one-hot active menu (food/drink/pay), 000 otherwise
//   nav_next/nav_back   : one-cycle navigation pulses to the active menu
//   order_food/drink/pay: latched choices
//   order_valid         : one-cycle pulse on the first DONE cycle
//   busy                : high in every state except IDLE
//   timeout             : one-cycle pulse on inactivity abort
module order_sequencer
    import order_pkg::*;
#(
    parameter int DEB_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DONE_CYCLES    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_next,
    input  logic               btn_back,
    input  logic               btn_sel,
    input  logic               btn_cancel,
    input  logic [FOOD_W-1:0]  food_code,
    input  logic [DRINK_W-1:0] drink_code,
    input  logic [PAY_W-1:0]   pay_code,
    output logic [2:0]         stage_en,
    output logic               nav_next,
    output logic               nav_back,
    output logic [FOOD_W-1:0]  order_food,
    output logic [DRINK_W-1:0] order_drink,
    output logic [PAY_W-1:0]   order_pay,
    output logic               order_valid,
    output logic               busy,
    output logic               timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DW = $clog2(DONE_CYCLES + 1);

    // ---------------- button front end ----------------
    logic ev_next, ev_back, ev_sel, ev_cancel;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk(clk), .rst_n(reset), .btn_i(btn_next), .event_o(ev_next)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_back (
        .clk(clk), .rst_n(reset), .btn_i(btn_back), .event_o(ev_back)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
        .clk(clk), .rst_n(reset), .btn_i(btn_sel), .event_o(ev_sel)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cancel (
        .clk(clk), .rst_n(reset), .btn_i(btn_cancel), .event_o(ev_cancel)
    );

    // ---------------- arbitration: cancel > sel > back > next ----------------
    // Losing events are dropped outright, never queued.
    logic win_cancel, win_sel, win_back, win_next, any_ev;

    assign win_cancel = ev_cancel;
    assign win_sel    = ev_sel  & ~ev_cancel;
    assign win_back   = ev_back & ~ev_sel & ~ev_cancel;
    assign win_next   = ev_next & ~ev_back & ~ev_sel & ~ev_cancel;
    assign any_ev     = ev_next | ev_back | ev_sel | ev_cancel;

    // ---------------- controller state ----------------
    state_e             state_q, state_d;
    logic [TW-1:0]      idle_cnt_q, idle_cnt_d;
    logic [DW-1:0]      done_cnt_q, done_cnt_d;
    logic [FOOD_W-1:0]  food_q, food_d;
    logic [DRINK_W-1:0] drink_q, drink_d;
    logic [PAY_W-1:0]   pay_q, pay_d;
    logic [2:0]         stage_en_q, stage_en_d;
    logic               busy_q, busy_d;
    logic               nav_next_q, nav_next_d;
    logic               nav_back_q, nav_back_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;
    logic               active;
    logic               clear;

    assign active = (state_q == FOOD) || (state_q == DRINK) ||
                    (state_q == PAY)  || (state_q == CONFIRM);

    always_comb begin
        state_d    = state_q;
        done_cnt_d = done_cnt_q;
        food_d     = food_q;
        drink_d    = drink_q;
        pay_d      = pay_q;
        nav_next_d = 1'b0;
        nav_back_d = 1'b0;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;
        clear      = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_ev) state_d = FOOD;
            end
            FOOD, DRINK, PAY, CONFIRM: begin
                if (win_cancel) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end else if (win_sel) begin
                    case (state_q)
                        FOOD: begin
                            food_d  = food_code;
                            state_d = DRINK;
                        end
                        DRINK: begin
                            drink_d = drink_code;
                            state_d = PAY;
                        end
                        PAY: begin
                            pay_d   = pay_code;
                            state_d = CONFIRM;
                        end
                        default: begin
                            state_d = DONE;
                            valid_d = 1'b1;
                        end
                    endcase
                end else if (win_back || win_next) begin
                    // CONFIRM has no menu to navigate.
                    if (state_q != CONFIRM) begin
                        nav_back_d = win_back;
                        nav_next_d = win_next;
                    end
                end else if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Expiry only when no event arrived this cycle.
                    state_d   = IDLE;
                    clear     = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                // Events, cancel included, are ignored while the order is shown.
                if (done_cnt_q == DW'(DONE_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    done_cnt_d = done_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_d == DONE) && (state_q != DONE)) done_cnt_d = '0;

        if (clear) begin
            food_d  = '0;
            drink_d = '0;
            pay_d   = '0;
        end

        if (!active || any_ev || (state_d != state_q)) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != TW'(TIMEOUT_CYCLES)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q;
        end

        // Decoded from the next state so the outputs line up with the state.
        stage_en_d = stage_of(state_d);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idle_cnt_q <= '0;
            done_cnt_q <= '0;
            food_q     <= '0;
            drink_q    <= '0;
            pay_q      <= '0;
            stage_en_q <= STAGE_NONE;
            busy_q     <= 1'b0;
            nav_next_q <= 1'b0;
            nav_back_q <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            done_cnt_q <= done_cnt_d;
            food_q     <= food_d;
            drink_q    <= drink_d;
            pay_q      <= pay_d;
            stage_en_q <= stage_en_d;
            busy_q     <= busy_d;
            nav_next_q <= nav_next_d;
            nav_back_q <= nav_back_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign stage_en    = stage_en_q;
    assign busy        = busy_q;
    assign nav_next    = nav_next_q;
    assign nav_back    = nav_back_q;
    assign order_food  = food_q;
    assign order_drink = drink_q;
    assign order_pay   = pay_q;
    assign order_valid = valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_order_sequencer.sv
// tb_order_sequencer
// Directed bench for order_sequencer with a behavioural reference model.
module tb_order_sequencer;

    localparam int DEB    = 4;
    localparam int TMO    = 64;
    localparam int DONE_N = 8;

    localparam int M_IDLE    = 0;
    localparam int M_FOOD    = 1;
    localparam int M_DRINK   = 2;
    localparam int M_PAY     = 3;
    localparam int M_CONFIRM = 4;
    localparam int M_DONE    = 5;

    // button mask bits: 0 next, 1 back, 2 sel, 3 cancel
    localparam logic [3:0] B_NEXT   = 4'b0001;
    localparam logic [3:0] B_BACK   = 4'b0010;
    localparam logic [3:0] B_SEL    = 4'b0100;
    localparam logic [3:0] B_CANCEL = 4'b1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_next = 1'b0, btn_back = 1'b0, btn_sel = 1'b0, btn_cancel = 1'b0;
    logic [1:0] food_code = 2'd0, drink_code = 2'd0;
    logic       pay_code = 1'b0;
    logic [2:0] stage_en;
    logic       nav_next, nav_back, order_valid, busy, timeout;
    logic [1:0] order_food, order_drink;
    logic       order_pay;

    order_sequencer #(
        .DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .DONE_CYCLES(DONE_N)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_next(btn_next), .btn_back(btn_back), .btn_sel(btn_sel), .btn_cancel(btn_cancel),
        .food_code(food_code), .drink_code(drink_code), .pay_code(pay_code),
        .stage_en(stage_en), .nav_next(nav_next), .nav_back(nav_back),
        .order_food(order_food), .order_drink(order_drink), .order_pay(order_pay),
        .order_valid(order_valid), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // observed pulse counts
    int cnt_nav_next = 0, cnt_nav_back = 0, cnt_valid = 0, cnt_timeout = 0;

    // ---------------- reference model ----------------
    logic [15:0] m_hist [4];
    logic        m_acc  [4];
    logic        m_accp [4];
    logic        m_ev   [4];
    int m_stage = M_IDLE;
    int m_idle = 0, m_done = 0;
    int m_food = 0, m_drink = 0, m_pay = 0;
    int m_nn = 0, m_nb = 0, m_valid = 0, m_tmo = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = '0; m_acc[i] = 1'b0; m_accp[i] = 1'b0; m_ev[i] = 1'b0;
        end
        m_stage = M_IDLE; m_idle = 0; m_done = 0;
        m_food = 0; m_drink = 0; m_pay = 0;
        m_nn = 0; m_nb = 0; m_valid = 0; m_tmo = 0;
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_step();
        logic [3:0] raw;
        int win, old;
        logic same;
        if (!reset) begin
            model_reset();
            return;
        end
        raw = {btn_cancel, btn_sel, btn_back, btn_next};
        win = -1;
        if (m_ev[0]) win = 0;
        if (m_ev[1]) win = 1;
        if (m_ev[2]) win = 2;
        if (m_ev[3]) win = 3;
        old = m_stage;
        m_nn = 0; m_nb = 0; m_valid = 0; m_tmo = 0;
        if (old == M_IDLE) begin
            if (win >= 0) m_stage = M_FOOD;
        end else if (old == M_DONE) begin
            m_done++;
            if (m_done >= DONE_N) m_stage = M_IDLE;
        end else begin
            if (win == 3) begin
                m_stage = M_IDLE; m_food = 0; m_drink = 0; m_pay = 0;
            end else if (win == 2) begin
                if (old == M_FOOD)    m_food  = int'(food_code);
                if (old == M_DRINK)   m_drink = int'(drink_code);
                if (old == M_PAY)     m_pay   = int'(pay_code);
                if (old == M_CONFIRM) m_valid = 1;
                m_stage = old + 1;
            end else if (win >= 0) begin
                if (old != M_CONFIRM) begin
                    if (win == 1) m_nb = 1; else m_nn = 1;
                end
            end else begin
                m_idle++;
                if (m_idle >= TMO) begin
                    m_stage = M_IDLE; m_food = 0; m_drink = 0; m_pay = 0; m_tmo = 1;
                end
            end
            if (win >= 0) m_idle = 0;
        end
        if (m_stage != old) begin
            m_idle = 0; m_done = 0;
        end
        // event = accepted level rose at the previous edge
        for (int i = 0; i < 4; i++) begin
            m_ev[i]   = m_acc[i] & ~m_accp[i];
            m_accp[i] = m_acc[i];
        end
        // accepted level follows DEB equal synchronised samples (raw two edges back)
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = {m_hist[i][14:0], raw[i]};
            same = 1'b1;
            for (int j = 3; j <= DEB + 1; j++)
                if (m_hist[i][j] != m_hist[i][2]) same = 1'b0;
            if (same) m_acc[i] = m_hist[i][2];
        end
    endtask

    function automatic int exp_stage(input int s);
        case (s)
            M_FOOD:  return 1;
            M_DRINK: return 2;
            M_PAY:   return 4;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("stage_en", int'(stage_en), exp_stage(m_stage));
        check("busy", int'(busy), (m_stage != M_IDLE) ? 1 : 0);
        check("nav_next", int'(nav_next), m_nn);
        check("nav_back", int'(nav_back), m_nb);
        check("order_food", int'(order_food), m_food);
        check("order_drink", int'(order_drink), m_drink);
        check("order_pay", int'(order_pay), m_pay);
        check("order_valid", int'(order_valid), m_valid);
        check("timeout", int'(timeout), m_tmo);
        if (nav_next) cnt_nav_next++;
        if (nav_back) cnt_nav_back++;
        if (order_valid) cnt_valid++;
        if (timeout) cnt_timeout++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_btns(input logic [3:0] m);
        btn_next = m[0]; btn_back = m[1]; btn_sel = m[2]; btn_cancel = m[3];
    endtask

    // Returns on the first cycle in which the FSM has acted on the event.
    task automatic press_hold(input logic [3:0] m);
        set_btns(m);
        repeat (8) tick();
    endtask

    task automatic release_all();
        set_btns(4'b0000);
        repeat (8) tick();
    endtask

    task automatic press(input logic [3:0] m);
        press_hold(m);
        release_all();
    endtask

    int k, c0, c1;

    initial begin
        model_reset();
        #1 reset = 1'b0;
        tick();
        check("reset_stage_en", int'(stage_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_order_food", int'(order_food), 0);
        tick();
        reset = 1'b1;
        tick();

        // ---- bounce filtering ----
        c0 = cnt_nav_next;
        for (int i = 0; i < 6; i++) begin
            btn_next = (i % 2 == 0);
            tick();
        end
        btn_next = 1'b1;
        k = 0;
        while (stage_en != 3'b001 && k < 30) begin
            tick();
            k++;
        end
        check("bounce_to_food_cycles", k, 8);
        release_all();
        check("bounce_no_nav", cnt_nav_next - c0, 0);

        // navigation inside FOOD, then cancel
        c0 = cnt_nav_next; c1 = cnt_nav_back;
        press(B_NEXT);
        check("food_nav_next", cnt_nav_next - c0, 1);
        press(B_BACK);
        check("food_nav_back", cnt_nav_back - c1, 1);
        check("food_stage", int'(stage_en), 1);
        press(B_CANCEL);
        check("cancel_busy", int'(busy), 0);

        // ---- full order ----
        press(B_NEXT);
        check("order_enter_food", int'(stage_en), 1);
        c0 = cnt_nav_next;
        press(B_NEXT);
        check("order_nav", cnt_nav_next - c0, 1);
        food_code = 2'd2;
        press(B_SEL);
        check("order_drink_stage", int'(stage_en), 2);
        drink_code = 2'd1;
        press(B_SEL);
        check("order_pay_stage", int'(stage_en), 4);
        pay_code = 1'b1;
        press(B_SEL);
        check("confirm_stage_en", int'(stage_en), 0);
        check("confirm_busy", int'(busy), 1);
        c0 = cnt_nav_next;
        press(B_NEXT);
        check("confirm_no_nav", cnt_nav_next - c0, 0);
        c1 = cnt_valid;
        press_hold(B_SEL);
        check("valid_pulse", int'(order_valid), 1);
        check("valid_food", int'(order_food), 2);
        check("valid_drink", int'(order_drink), 1);
        check("valid_pay", int'(order_pay), 1);
        set_btns(4'b0000);
        k = 0;
        while (busy && k < 30) begin
            tick();
            k++;
        end
        check("done_length", k, 8);
        check("valid_once", cnt_valid - c1, 1);
        check("held_food", int'(order_food), 2);
        repeat (2) tick();

        // ---- DONE lockout ----
        press(B_NEXT);
        food_code = 2'd1;  press(B_SEL);
        drink_code = 2'd3; press(B_SEL);
        pay_code = 1'b0;   press(B_SEL);
        set_btns(B_SEL);
        tick();
        set_btns(B_SEL | B_CANCEL | B_NEXT);
        repeat (7) tick();
        check("lock_valid", int'(order_valid), 1);
        k = 0;
        while (busy && k < 30) begin
            tick();
            k++;
        end
        check("lock_done_length", k, 8);
        check("lock_food", int'(order_food), 1);
        check("lock_drink", int'(order_drink), 3);
        check("lock_pay", int'(order_pay), 0);
        release_all();

        // ---- simultaneous events ----
        press(B_NEXT);
        food_code = 2'd3; press(B_SEL);
        drink_code = 2'd2;
        c0 = cnt_nav_next;
        press(B_SEL | B_NEXT);
        check("simul_pay_stage", int'(stage_en), 4);
        check("simul_drink_latched", int'(order_drink), 2);
        check("simul_no_nav", cnt_nav_next - c0, 0);
        press(B_CANCEL | B_SEL);
        check("cancel_sel_busy", int'(busy), 0);
        check("cancel_sel_food", int'(order_food), 0);
        check("cancel_sel_drink", int'(order_drink), 0);

        // ---- timeout ----
        press_hold(B_NEXT);
        set_btns(4'b0000);
        c0 = cnt_timeout;
        k = 0;
        while (!timeout && k < 100) begin
            tick();
            k++;
        end
        check("timeout_cycles", k, 64);
        check("timeout_busy", int'(busy), 0);
        repeat (3) tick();
        check("timeout_once", cnt_timeout - c0, 1);

        // event in the expiry cycle wins
        press_hold(B_NEXT);
        set_btns(4'b0000);
        c0 = cnt_timeout; c1 = cnt_nav_next;
        repeat (56) tick();
        set_btns(B_NEXT);
        repeat (8) tick();
        check("late_press_nav", cnt_nav_next - c1, 1);
        set_btns(4'b0000);
        repeat (16) tick();
        check("late_press_no_timeout", cnt_timeout - c0, 0);
        check("late_press_stage", int'(stage_en), 1);
        press(B_CANCEL);

        // ---- asynchronous reset mid-PAY ----
        press(B_NEXT);
        food_code = 2'd1;  press(B_SEL);
        drink_code = 2'd2; press(B_SEL);
        check("pre_reset_stage", int'(stage_en), 4);
        @(posedge clk);
        model_step();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("async_stage_en", int'(stage_en), 0);
        check("async_busy", int'(busy), 0);
        check("async_food", int'(order_food), 0);
        check("async_drink", int'(order_drink), 0);
        @(negedge clk);
        compare_all();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        press_hold(B_NEXT);
        check("after_reset_food", int'(stage_en), 1);
        release_all();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/order_sequencer.md
Name: order_sequencer

Overview:
Central controller for the food/drink/payment ordering chain on the TinyFPGA BX. It synchronises and debounces the four panel buttons and steps through the stages food, drink, payment and confirm. It routes navigation pulses only to the active menu stage and latches each stage's choice. It emits a single order-complete pulse with the full order, and returns to idle on cancel or inactivity timeout.

Parameters:
DEB_CYCLES, 4, number of consecutive stable clk samples before a button level is accepted (min 1)
TIMEOUT_CYCLES, 64, inactivity count in any active stage before abort to IDLE (min 2)
DONE_CYCLES, 8, cycles the DONE state is held before returning to IDLE (min 1)

Ports:
clk  in  1  system clock (divided tick from top)
reset  in  1  asynchronous, active-low reset
btn_next  in  1  raw button "next" (AD), active-high, asynchronous to clk
btn_back  in  1  raw button "back" (AT), active-high, asynchronous
btn_sel  in  1  raw button "select" (SEL), active-high, asynchronous
btn_cancel  in  1  raw button "cancel" (CLC), active-high, asynchronous
food_code  in  2  current highlighted food option from the food menu
drink_code  in  2  current highlighted drink option from the drink menu
pay_code  in  1  current payment option from the payment menu (0 = cash, 1 = card)
stage_en  out  3  one-hot active stage: bit0 food, bit1 drink, bit2 pay; 000 otherwise
nav_next  out  1  one-cycle pulse to the active menu
nav_back  out  1  one-cycle pulse to the active menu
order_food  out  2  latched food choice
order_drink  out  2  latched drink choice
order_pay  out  1  latched payment choice
order_valid  out  1  one-cycle pulse when the order is confirmed
busy  out  1  high in any state except IDLE
timeout  out  1  one-cycle pulse on inactivity abort

Behaviour:
- Reset (reset = 0, async):
  - State is IDLE.
  - All outputs are 0.
  - Synchroniser, debounce and inactivity counters are cleared.
  - Deasserting reset mid-operation always restarts from IDLE.
- Input path, per button:
  - 2-flop synchroniser.
  - Debounce: the accepted level changes only after DEB_CYCLES consecutive equal synchronised samples.
  - Event = rising edge of the accepted level, one cycle long.
  - Raw press to event latency = 2 + DEB_CYCLES + 1 clk.
  - Release generates no event.
- Event arbitration, one event per cycle:
  - Priority cancel > sel > back > next.
  - Lower-priority events in the same cycle are discarded, not queued.
- States: IDLE, FOOD, DRINK, PAY, CONFIRM, DONE.
- IDLE:
  - Any event goes to FOOD.
  - Latches are not cleared on entry; they are cleared on cancel or timeout.
- FOOD, DRINK, PAY:
  - next/back: nav_next/nav_back pulse on the cycle after the event. State is unchanged.
  - sel: latch the stage's code input on the event cycle. Go to DRINK, PAY or CONFIRM respectively. No nav pulse.
- CONFIRM:
  - sel goes to DONE, and order_valid pulses for exactly the first DONE cycle.
  - next/back are ignored; no nav pulse.
- DONE:
  - All events are ignored, including cancel.
  - After DONE_CYCLES cycles, go to IDLE.
  - Latched order values are held until the next cancel or timeout, or overwritten by new selections.
- Cancel, in FOOD, DRINK, PAY or CONFIRM: next state IDLE, all order_* latches cleared to 0. No order_valid.
- Inactivity:
  - The counter runs in FOOD..CONFIRM and resets on any accepted event or any state change.
  - On reaching TIMEOUT_CYCLES: go to IDLE, clear the latches, pulse timeout for one cycle.
  - If an event arrives in the same cycle the counter expires, the event wins and the counter resets.
- Outputs:
  - stage_en, busy and nav_* are registered and decoded from state.
  - stage_en is 000 in IDLE, CONFIRM and DONE.
  - busy is 1 in DONE.
- The counter widths are sized from the parameters ($clog2(param+1)). Counters saturate and never wrap.

Decomposition:
- Shared package order_pkg:
  - state enum (IDLE, FOOD, DRINK, PAY, CONFIRM, DONE)
  - FOOD_W = 2, DRINK_W = 2, PAY_W = 1
  - stage_en one-hot constants
- Sub-module btn_debounce (sync + debounce + rise-edge event), instantiated four times with DEB_CYCLES passed down.
- Arbitration and the FSM live in order_sequencer.

Test Plan:
1. Bounce filtering: with DEB_CYCLES = 4, toggle btn_next 1-0-1 each cycle for 6 cycles, then hold it high. Exactly one event appears, 7 clk after the hold starts; nav_next does not pulse (from IDLE the event only moves to FOOD).
2. Full order: from IDLE, press next, then next (nav_next pulse, stage_en = 001). Then sel with food_code = 2, sel with drink_code = 1, sel with pay_code = 1, then sel in CONFIRM. Required: order_valid is one cycle with order_food = 2, order_drink = 1, order_pay = 1; busy drops 8 cycles later.
3. Simultaneous events: in DRINK, assert sel and next in the same cycle. State goes to PAY with drink latched and no nav_next. Then cancel + sel in PAY: state goes to IDLE with all latches 0.
4. Timeout: with TIMEOUT_CYCLES = 64, enter FOOD and stay idle. After 64 cycles, timeout pulses once, state is IDLE and busy = 0. A press at cycle 63 instead resets the count and there is no timeout.
5. DONE lockout: press cancel and next during DONE. The order_* outputs are unchanged, and the return to IDLE still happens exactly DONE_CYCLES after entry.
6. Async reset: assert reset low mid-PAY between clock edges. All outputs go to 0 immediately. After release, the first event goes to FOOD.
